// File: rtl/mux_pkg.sv
// Shared helpers for the mux/demux family: channel-index width sizing.
package mux_pkg;

  // Never returns 0, so a select port always has at least one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_mux_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr,
// then moves ptr just past the winner when the grant is consumed.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUMIN  = 16,
  parameter int unsigned SWIDTH = sel_width(NUMIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUMIN-1:0]  req,
  input  logic              advance,
  output logic              gnt_v,
  output logic [SWIDTH-1:0] gnt_idx
);

  localparam logic [SWIDTH-1:0] LAST = SWIDTH'(NUMIN - 1);

  logic [SWIDTH-1:0] ptr;
  logic [SWIDTH-1:0] idx;

  // Walk once around the ring starting at ptr, wrapping at NUMIN-1.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    idx     = ptr;
    for (int unsigned k = 0; k < NUMIN; k++) begin
      if (!gnt_v && req[idx]) begin
        gnt_v   = 1'b1;
        gnt_idx = idx;
      end
      idx = (idx == LAST) ? '0 : idx + SWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && gnt_v) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + SWIDTH'(1);
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-to-1 round-robin mux: per-channel one-entry holding registers drained
// into a registered, source-tagged output stream with backpressure.
module rr_mux
  import mux_pkg::*;
#(
  parameter int unsigned NUMIN  = 16,
  parameter int unsigned DWIDTH = 14,
  parameter int unsigned SWIDTH = sel_width(NUMIN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUMIN*DWIDTH-1:0] din_vec,
  input  logic [NUMIN-1:0]        din_vec_v,
  output logic [NUMIN-1:0]        din_vec_rdy,
  output logic [DWIDTH-1:0]       dout,
  output logic                    dout_v,
  output logic [SWIDTH-1:0]       dout_sel,
  input  logic                    dout_rdy
);

  logic [DWIDTH-1:0] hold [NUMIN];
  logic [NUMIN-1:0]  full;
  logic              out_free;
  logic              gnt_v;
  logic [SWIDTH-1:0] gnt_idx;
  logic              grant;

  assign din_vec_rdy = ~full & {NUMIN{~rst}};
  assign out_free    = !dout_v || dout_rdy;
  assign grant       = out_free && gnt_v;

  rr_arbiter #(
    .NUMIN  (NUMIN),
    .SWIDTH (SWIDTH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (full),
    .advance (out_free),
    .gnt_v   (gnt_v),
    .gnt_idx (gnt_idx)
  );

  // A granted channel is full, so its rdy is low and it cannot capture
  // in the same edge; clear and capture never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      for (int unsigned i = 0; i < NUMIN; i++) hold[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUMIN; i++) begin
        if (grant && (gnt_idx == SWIDTH'(i))) begin
          full[i] <= 1'b0;
        end else if (din_vec_v[i] && din_vec_rdy[i]) begin
          full[i] <= 1'b1;
          hold[i] <= din_vec[i*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      dout_sel <= '0;
      dout_v   <= 1'b0;
    end else if (out_free) begin
      if (gnt_v) begin
        dout     <= hold[gnt_idx];
        dout_sel <= gnt_idx;
        dout_v   <= 1'b1;
      end else begin
        dout_v   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: a 16-channel instance plus a 5-channel one
// for the non-power-of-2 pointer wrap.
module tb_rr_mux;

  localparam int unsigned DW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [16*DW-1:0] din;
  logic [15:0]   din_v;
  logic [15:0]   din_rdy;
  logic [DW-1:0] dout;
  logic          dout_v;
  logic [3:0]    dout_sel;
  logic          dout_rdy;

  logic [5*DW-1:0] din5;
  logic [4:0]    din_v5;
  logic [4:0]    din_rdy5;
  logic [DW-1:0] dout5;
  logic          dout_v5;
  logic [2:0]    dout_sel5;
  logic          dout_rdy5;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  rr_mux #(.NUMIN(16), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .din_vec(din), .din_vec_v(din_v),
    .din_vec_rdy(din_rdy), .dout(dout), .dout_v(dout_v),
    .dout_sel(dout_sel), .dout_rdy(dout_rdy)
  );

  rr_mux #(.NUMIN(5), .DWIDTH(DW)) dut5 (
    .clk(clk), .rst(rst), .din_vec(din5), .din_vec_v(din_v5),
    .din_vec_rdy(din_rdy5), .dout(dout5), .dout_v(dout_v5),
    .dout_sel(dout_sel5), .dout_rdy(dout_rdy5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_v = '0;
    din_v5 = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) step();
    total++;
    if (din_rdy !== 16'h0000 || dout_v !== 1'b0 || dout !== '0 || dout_sel !== '0) begin
      bad++;
      $display("FAIL reset_state: rdy=%h v=%b dout=%h sel=%0d want rdy=0000 v=0 dout=0 sel=0",
               din_rdy, dout_v, dout, dout_sel);
    end
    rst = 1'b0;
    step();
    total++;
    if (din_rdy !== 16'hFFFF || dout_v !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rdy=%h v=%b want rdy=ffff v=0", din_rdy, dout_v);
    end
  endtask

  task automatic test_single();
    din[5*DW +: DW] = 14'h0123;
    din_v[5] = 1'b1;
    step();
    din_v = '0;
    total++;
    if (din_rdy[5] !== 1'b0 || dout_v !== 1'b0) begin
      bad++;
      $display("FAIL single_capture: rdy5=%b v=%b want rdy5=0 v=0", din_rdy[5], dout_v);
    end
    step();
    total++;
    if (dout_v !== 1'b1 || dout !== 14'h0123 || dout_sel !== 4'd5) begin
      bad++;
      $display("FAIL single_beat: v=%b dout=%h sel=%0d want v=1 dout=0123 sel=5",
               dout_v, dout, dout_sel);
    end
    total++;
    if (din_rdy[5] !== 1'b1) begin
      bad++;
      $display("FAIL single_rdy_back: rdy5=%b want 1", din_rdy[5]);
    end
    step();
    total++;
    if (dout_v !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: v=%b want 0", dout_v);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 16; i++) din[i*DW +: DW] = DW'(i + 1);
    din_v = 16'hFFFF;
    step();
    din_v = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      total++;
      if (dout_v !== 1'b1 || dout_sel !== 4'(i) || dout !== DW'(i + 1)) begin
        bad++;
        $display("FAIL fair_beat%0d: v=%b sel=%0d dout=%0d want v=1 sel=%0d dout=%0d",
                 i, dout_v, dout_sel, dout, i, i + 1);
      end
    end
    step();
    total++;
    if (dout_v !== 1'b0) begin
      bad++;
      $display("FAIL fair_end: v=%b want 0", dout_v);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] order [3];
    order[0] = 4'd15;
    order[1] = 4'd0;
    order[2] = 4'd2;
    din[14*DW +: DW] = 14'h0E0E;
    din_v = 16'h4000;
    step();
    din_v = '0;
    step();
    total++;
    if (dout_v !== 1'b1 || dout_sel !== 4'd14) begin
      bad++;
      $display("FAIL wrap_ch14: v=%b sel=%0d want v=1 sel=14", dout_v, dout_sel);
    end
    din[2*DW +: DW]  = 14'h0222;
    din[15*DW +: DW] = 14'h0FFF;
    din[0 +: DW]     = 14'h0100;
    din_v = 16'h8005;
    step();
    din_v = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (dout_v !== 1'b1 || dout_sel !== order[i]) begin
        bad++;
        $display("FAIL wrap_order%0d: v=%b sel=%0d want v=1 sel=%0d",
                 i, dout_v, dout_sel, order[i]);
      end
    end
    step();
    // five-channel instance: full sweep, then ptr back at 0
    for (int i = 0; i < 5; i++) din5[i*DW +: DW] = DW'(10 + i);
    din_v5 = 5'h1F;
    step();
    din_v5 = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (dout_v5 !== 1'b1 || dout_sel5 !== 3'(i) || dout5 !== DW'(10 + i)) begin
        bad++;
        $display("FAIL n5_beat%0d: v=%b sel=%0d dout=%0d want v=1 sel=%0d dout=%0d",
                 i, dout_v5, dout_sel5, dout5, i, 10 + i);
      end
    end
    din5[0 +: DW]    = 14'h0050;
    din5[3*DW +: DW] = 14'h0053;
    din_v5 = 5'h09;
    step();
    din_v5 = '0;
    step();
    total++;
    if (dout_v5 !== 1'b1 || dout_sel5 !== 3'd0 || dout5 !== 14'h0050) begin
      bad++;
      $display("FAIL n5_wrap0: v=%b sel=%0d dout=%h want v=1 sel=0 dout=0050",
               dout_v5, dout_sel5, dout5);
    end
    step();
    total++;
    if (dout_v5 !== 1'b1 || dout_sel5 !== 3'd3 || dout5 !== 14'h0053) begin
      bad++;
      $display("FAIL n5_next3: v=%b sel=%0d dout=%h want v=1 sel=3 dout=0053",
               dout_v5, dout_sel5, dout5);
    end
    step();
  endtask

  task automatic test_backpressure();
    // ptr sits at 3 after the wrap test
    din[3*DW +: DW] = 14'h0AAA;
    din[7*DW +: DW] = 14'h0BBB;
    din_v = 16'h0088;
    dout_rdy = 1'b0;
    step();
    din_v = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (dout_v !== 1'b1 || dout !== 14'h0AAA || dout_sel !== 4'd3 || din_rdy[7] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: v=%b dout=%h sel=%0d rdy7=%b want v=1 dout=0aaa sel=3 rdy7=0",
                 i, dout_v, dout, dout_sel, din_rdy[7]);
      end
    end
    dout_rdy = 1'b1;
    step();
    total++;
    if (dout_v !== 1'b1 || dout !== 14'h0BBB || dout_sel !== 4'd7) begin
      bad++;
      $display("FAIL bp_release: v=%b dout=%h sel=%0d want v=1 dout=0bbb sel=7",
               dout_v, dout, dout_sel);
    end
    step();
    total++;
    if (dout_v !== 1'b0 || din_rdy !== 16'hFFFF) begin
      bad++;
      $display("FAIL bp_drain: v=%b rdy=%h want v=0 rdy=ffff", dout_v, din_rdy);
    end
  endtask

  task automatic test_async_reset();
    // ptr sits at 8; four beats pending behind a stalled output
    for (int i = 0; i < 16; i++) din[i*DW +: DW] = DW'(16'h0300 + i);
    din_v = 16'h1212;
    dout_rdy = 1'b0;
    step();
    din_v = '0;
    step();
    total++;
    if (dout_v !== 1'b1 || dout_sel !== 4'd9) begin
      bad++;
      $display("FAIL ar_pre: v=%b sel=%0d want v=1 sel=9", dout_v, dout_sel);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (dout_v !== 1'b0 || dout !== '0 || dout_sel !== '0 || din_rdy !== 16'h0000) begin
      bad++;
      $display("FAIL ar_immediate: v=%b dout=%h sel=%0d rdy=%h want all 0",
               dout_v, dout, dout_sel, din_rdy);
    end
    step();
    rst = 1'b0;
    dout_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (dout_v !== 1'b0 || din_rdy !== 16'hFFFF) begin
        bad++;
        $display("FAIL ar_stale%0d: v=%b rdy=%h want v=0 rdy=ffff", i, dout_v, din_rdy);
      end
    end
    din_v = 16'hFFFF;
    step();
    din_v = '0;
    step();
    total++;
    if (dout_v !== 1'b1 || dout_sel !== 4'd0 || dout !== 14'h0300) begin
      bad++;
      $display("FAIL ar_first: v=%b sel=%0d dout=%h want v=1 sel=0 dout=0300",
               dout_v, dout_sel, dout);
    end
    for (int i = 0; i < 16; i++) step();
  endtask

  initial begin
    din = '0;
    din_v = '0;
    dout_rdy = 1'b1;
    din5 = '0;
    din_v5 = '0;
    dout_rdy5 = 1'b1;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
